// File: rtl/varredura_teclado_if.sv
// Key-matrix scanner bus: matrix drive/sense lines plus the key-code handshake.
interface varredura_teclado_if;
    logic       enable;
    logic [6:0] linhas;
    logic [4:0] colunas;
    logic [2:0] contador;
    logic       tecla_valida;
    logic [5:0] tecla_codigo;
    logic       tecla_ack;
    logic       erro_multipla;

    // Scanner side
    modport master (
        input  enable, linhas, tecla_ack,
        output colunas, contador, tecla_valida, tecla_codigo, erro_multipla
    );

    // Matrix / consumer side
    modport slave (
        output enable, linhas, tecla_ack,
        input  colunas, contador, tecla_valida, tecla_codigo, erro_multipla
    );
endinterface

// File: rtl/varredura_teclado.sv
// 5x7 key-matrix scanner with frame-level debounce and valid/ack key reporting.
module varredura_teclado #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    varredura_teclado_if.master bus
);
    localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_N     = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, REPORT, WAIT_RELEASE} estado_t;

    // Rows are stored inverted: 1 = key closed, so reset value 0 means "not pressed".
    logic [6:0]  linhas_s1, linhas_s2;
    logic [15:0] presc;
    logic [2:0]  contador_q, contador_prox;
    logic [4:0]  colunas_q;
    // Frame accumulator: frame_n is the closed-key count saturated at 2 (2 = multiple).
    logic [1:0]  frame_n, n_novo;
    logic [5:0]  frame_cod, cod_novo;
    logic [2:0]  hits, row;
    logic [5:0]  code_col;
    logic        amostra, fim_quadro;
    estado_t     estado;
    logic [3:0]  fcnt;
    logic [5:0]  cand;
    logic        valida_q, erro_q;
    logic [5:0]  codigo_q;

    assign amostra       = bus.enable && (presc == PRESC_MAX);
    assign fim_quadro    = amostra && (contador_q == 3'd4);
    assign contador_prox = (contador_q == 3'd4) ? 3'd0 : contador_q + 3'd1;
    assign code_col      = 6'(contador_q) * 6'd7 + 6'(row);

    // Count closed rows in the sampled column and remember the (last) closed row index.
    always_comb begin
        hits = '0;
        row  = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (linhas_s2[i]) begin
                hits = hits + 3'd1;
                row  = 3'(i);
            end
        end
    end

    // Fold this column's sample into the running frame classification.
    always_comb begin
        n_novo   = frame_n;
        cod_novo = frame_cod;
        if (hits >= 3'd2 || (hits == 3'd1 && frame_n != 2'd0)) begin
            n_novo = 2'd2;
        end else if (hits == 3'd1) begin
            n_novo   = 2'd1;
            cod_novo = code_col;
        end
    end

    // Two-flop synchronizer on the row sense lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            linhas_s1 <= '0;
            linhas_s2 <= '0;
        end else begin
            linhas_s1 <= ~bus.linhas;
            linhas_s2 <= linhas_s1;
        end
    end

    // Prescaler, column counter, column drive and per-frame accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.enable) begin
            presc      <= '0;
            contador_q <= '0;
            colunas_q  <= '1;
            frame_n    <= '0;
            frame_cod  <= '0;
        end else begin
            // Drive is computed from the next column so colunas tracks contador on every cycle.
            colunas_q <= ~(5'd1 << (amostra ? contador_prox : contador_q));
            if (amostra) begin
                presc      <= '0;
                contador_q <= contador_prox;
                if (contador_q == 3'd4) begin
                    frame_n   <= '0;
                    frame_cod <= '0;
                end else begin
                    frame_n   <= n_novo;
                    frame_cod <= cod_novo;
                end
            end else begin
                presc <= presc + 16'd1;
            end
        end
    end

    // Debounce / report / release FSM driven by frame classifications.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.enable) begin
            estado   <= IDLE;
            fcnt     <= '0;
            valida_q <= 1'b0;
            erro_q   <= 1'b0;
            if (!rst_n) begin
                cand     <= '0;
                codigo_q <= '0;
            end
        end else begin
            erro_q <= 1'b0;
            unique case (estado)
                IDLE: begin
                    if (fim_quadro) begin
                        if (n_novo == 2'd1) begin
                            cand <= cod_novo;
                            fcnt <= 4'd1;
                            if (DEB_N == 4'd1) begin
                                estado   <= REPORT;
                                valida_q <= 1'b1;
                                codigo_q <= cod_novo;
                            end else begin
                                estado <= DEBOUNCE;
                            end
                        end else if (n_novo == 2'd2) begin
                            erro_q <= 1'b1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (fim_quadro) begin
                        if (n_novo == 2'd1 && cod_novo == cand) begin
                            fcnt <= fcnt + 4'd1;
                            if (fcnt + 4'd1 == DEB_N) begin
                                estado   <= REPORT;
                                valida_q <= 1'b1;
                                codigo_q <= cand;
                            end
                        end else begin
                            estado <= IDLE;
                            fcnt   <= '0;
                            erro_q <= (n_novo == 2'd2);
                        end
                    end
                end
                REPORT: begin
                    // Frame ends here are ignored; only the ack moves on.
                    if (bus.tecla_ack) begin
                        estado   <= WAIT_RELEASE;
                        fcnt     <= '0;
                        valida_q <= 1'b0;
                    end
                end
                WAIT_RELEASE: begin
                    if (fim_quadro) begin
                        if (n_novo == 2'd0) begin
                            if (fcnt + 4'd1 == DEB_N) begin
                                estado <= IDLE;
                                fcnt   <= '0;
                            end else begin
                                fcnt <= fcnt + 4'd1;
                            end
                        end else begin
                            fcnt <= '0;
                        end
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

    assign bus.colunas       = colunas_q;
    assign bus.contador      = contador_q;
    assign bus.tecla_valida  = valida_q;
    assign bus.tecla_codigo  = codigo_q;
    assign bus.erro_multipla = erro_q;
endmodule

// File: tb/tb_varredura_teclado.sv
// Bench for varredura_teclado: frame-level reference model, directed and random key patterns.
module tb_varredura_teclado;
    localparam int DF    = 2;
    localparam int FRAME = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    varredura_teclado_if bus();

    varredura_teclado #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Key matrix: a closed key pulls its row low while its column is driven.
    logic [34:0] teclas;
    logic [6:0]  lin;
    always_comb begin
        lin = '1;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 7; r++)
                if (bus.colunas[c] == 1'b0 && teclas[c*7+r]) lin[r] = 1'b0;
    end
    assign bus.linhas = lin;

    int checks   = 0;
    int failures = 0;

    // Reference model state (frame-level view)
    int n;            // scan edges since reset / enable
    bit m_valida;
    int m_codigo;
    bit m_erro;
    int streak, scode;
    bit esperando;
    int soltos;

    task automatic checar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [34:0] tecla(input int i);
        logic [34:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int conta(input logic [34:0] k);
        int s = 0;
        for (int i = 0; i < 35; i++) if (k[i]) s++;
        return s;
    endfunction

    function automatic int primeiro(input logic [34:0] k);
        for (int i = 0; i < 35; i++) if (k[i]) return i;
        return 0;
    endfunction

    // Applies the effect of one clock edge, using the inputs seen at that edge.
    task automatic modelo();
        int cnt, cod;
        if (!rst_n) begin
            n = 0; m_valida = 0; m_codigo = 0; m_erro = 0;
            streak = 0; esperando = 0; soltos = 0;
        end else if (!bus.enable) begin
            n = 0; m_valida = 0; m_erro = 0;
            streak = 0; esperando = 0; soltos = 0;
        end else begin
            n++;
            m_erro = 0;
            if (m_valida) begin
                if (bus.tecla_ack) begin
                    m_valida = 0; esperando = 1; soltos = 0;
                end
            end else if (n % FRAME == 0) begin
                cnt = conta(teclas);
                cod = primeiro(teclas);
                if (esperando) begin
                    if (cnt == 0) begin
                        soltos++;
                        if (soltos == DF) begin esperando = 0; soltos = 0; end
                    end else soltos = 0;
                end else if (cnt >= 2) begin
                    m_erro = 1; streak = 0;
                end else if (cnt == 1 && (streak == 0 || cod == scode)) begin
                    scode = cod;
                    streak++;
                    if (streak == DF) begin m_valida = 1; m_codigo = scode; streak = 0; end
                end else streak = 0;
            end
        end
    endtask

    task automatic comparar();
        int          ec;
        logic [4:0]  um;
        logic [4:0]  ecol;
        um   = 5'b00001;
        ec   = (n == 0) ? 0 : ((n % FRAME) / 4);
        ecol = (n == 0) ? 5'b11111 : ~(um << ec);
        checar("colunas", bus.colunas, ecol);
        checar("contador", bus.contador, ec);
        checar("tecla_valida", bus.tecla_valida, m_valida);
        checar("erro_multipla", bus.erro_multipla, m_erro);
        if (m_valida) checar("tecla_codigo", bus.tecla_codigo, m_codigo);
    endtask

    task automatic passo();
        @(posedge clk);
        modelo();
        @(negedge clk);
        comparar();
    endtask

    task automatic passos(input int k);
        for (int i = 0; i < k; i++) passo();
    endtask

    // Runs one full frame with the given closed keys; called on a frame boundary.
    task automatic quadro(input logic [34:0] k, input bit ack_rand);
        teclas = k;
        for (int i = 0; i < FRAME + 5; i++) begin
            if (ack_rand) bus.tecla_ack = ($urandom_range(0, 5) == 0);
            passo();
            if (n > 0 && n % FRAME == 0) begin
                bus.tecla_ack = 1'b0;
                return;
            end
        end
        bus.tecla_ack = 1'b0;
        checar("frame_sync", n % FRAME, 0);
    endtask

    task automatic ate_fronteira();
        for (int i = 0; i < FRAME + 5; i++) begin
            if (n % FRAME == 0) return;
            passo();
        end
        checar("boundary_sync", n % FRAME, 0);
    endtask

    task automatic ate_ultimo();
        for (int i = 0; i < FRAME + 5; i++) begin
            if (n % FRAME == FRAME - 1) return;
            passo();
        end
        checar("last_cycle_sync", n % FRAME, FRAME - 1);
    endtask

    task automatic pulso_ack();
        bus.tecla_ack = 1'b1;
        passo();
        bus.tecla_ack = 1'b0;
    endtask

    initial begin
        logic [34:0] prev;
        int          r, a, b;
        bus.enable    = 1'b1;
        bus.tecla_ack = 1'b0;
        teclas        = '0;
        rst_n         = 1'b0;
        n = 0; m_valida = 0; m_codigo = 0; m_erro = 0;
        streak = 0; scode = 0; esperando = 0; soltos = 0;

        // Reset state
        passos(2);
        checar("reset_codigo", bus.tecla_codigo, 0);
        checar("reset_colunas", bus.colunas, 5'b11111);
        rst_n = 1'b1;
        passo();
        checar("first_col", bus.colunas, 5'b11110);

        // Idle scan, then press code 17 (column 2, row 3)
        ate_fronteira();
        quadro('0, 0);
        quadro('0, 0);
        quadro(tecla(17), 0);
        quadro(tecla(17), 0);
        checar("press17_valida", bus.tecla_valida, 1'b1);
        checar("press17_codigo", bus.tecla_codigo, 17);
        quadro(tecla(17), 0);

        // Ack while held: no re-report, release, then code 34
        passos(3);
        pulso_ack();
        checar("ack_clear", bus.tecla_valida, 1'b0);
        ate_fronteira();
        quadro(tecla(17), 0);
        quadro(tecla(17), 0);
        quadro('0, 0);
        quadro('0, 0);
        quadro(tecla(34), 0);
        quadro(tecla(34), 0);
        checar("press34_codigo", bus.tecla_codigo, 34);

        // Ack coinciding with a ZERO frame end: that frame must not count as release
        teclas = '0;
        ate_ultimo();
        pulso_ack();
        quadro('0, 0);
        quadro(tecla(17), 0);
        quadro(tecla(17), 0);
        checar("ack_coincide_no_report", bus.tecla_valida, 1'b0);
        quadro('0, 0);
        quadro('0, 0);

        // Bounce
        quadro(tecla(17), 0);
        quadro('0, 0);
        quadro('0, 0);
        checar("bounce_valida", bus.tecla_valida, 1'b0);

        // Multiple keys (codes 0 and 8)
        quadro(tecla(0) | tecla(8), 0);
        checar("multi_pulse", bus.erro_multipla, 1'b1);
        quadro(tecla(0) | tecla(8), 0);
        quadro(tecla(0) | tecla(8), 0);
        quadro('0, 0);

        // Reset while reporting
        quadro(tecla(5), 0);
        quadro(tecla(5), 0);
        passos(7);
        rst_n = 1'b0;
        passo();
        rst_n = 1'b1;
        checar("rst_report_valida", bus.tecla_valida, 1'b0);
        checar("rst_report_codigo", bus.tecla_codigo, 0);
        teclas = '0;
        quadro('0, 0);

        // Enable dropped mid-frame, then scan restarts at column 0
        quadro(tecla(22), 0);
        passos(9);
        bus.enable = 1'b0;
        passo();
        checar("disable_colunas", bus.colunas, 5'b11111);
        passos(3);
        bus.enable = 1'b1;
        passo();
        checar("reenable_col0", bus.colunas, 5'b11110);
        ate_fronteira();
        quadro(tecla(22), 0);
        quadro(tecla(22), 0);
        checar("reenable_codigo", bus.tecla_codigo, 22);
        pulso_ack();
        ate_fronteira();
        quadro('0, 0);
        quadro('0, 0);

        // Random key patterns with random acks
        prev = tecla(3);
        for (int f = 0; f < 80; f++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                quadro('0, 1);
            end else if (r <= 6) begin
                quadro(prev, 1);
            end else if (r <= 8) begin
                prev = tecla($urandom_range(0, 34));
                quadro(prev, 1);
            end else begin
                a = $urandom_range(0, 34);
                b = (a + $urandom_range(1, 34)) % 35;
                quadro(tecla(a) | tecla(b), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/varredura_teclado.md
VARREDURA_TECLADO -- requirements
Module: varredura_teclado

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column is driven; legal range 4..65535.
REQ-002 Parameter DEBOUNCE_FRAMES, default 4: consecutive identical frames needed to accept a press or a release; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  1 = scan, 0 = scanner idle.
REQ-006 linhas  input  7  row sense lines from the key matrix, active-low (0 = key closed in the driven column).
REQ-007 colunas  output  5  column drive, one-hot active-low, bit i = column i.
REQ-008 contador  output  3  index (0..4) of the column currently driven.
REQ-009 tecla_valida  output  1  a debounced key code is available.
REQ-010 tecla_codigo  output  6  key code = column*7 + row (0..34); row r = linhas[r].
REQ-011 tecla_ack  input  1  consumer acknowledge.
REQ-012 erro_multipla  output  1  one-cycle pulse: two or more keys were closed in a frame.

Function
REQ-013 linhas SHALL pass through a 2-flop synchronizer before any use.
REQ-014 A prescaler SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and contador advances 0,1,2,3,4,0 (4 wraps to 0).
REQ-015 colunas SHALL be ~(1<<contador) when enable=1, and 5'b11111 when enable=0.
REQ-016 Synchronized rows SHALL be sampled only on the cycle the prescaler equals SCAN_DIV-1 (settling time >= SCAN_DIV-3 cycles).
REQ-017 A frame is the five column samples; it ends on the sample of column 4, and its classification is ZERO (no closed key), ONE (exactly one, with code), or MULTI (two or more).
REQ-018 FSM states: IDLE, DEBOUNCE, REPORT, WAIT_RELEASE; a frame count register fcnt (4 bits) is used.
REQ-019 IDLE: a ONE frame SHALL store the code, set fcnt=1, and go to DEBOUNCE; if DEBOUNCE_FRAMES=1, it SHALL go straight to REPORT.
REQ-020 DEBOUNCE: a ONE frame with the same code SHALL increment fcnt; when fcnt reaches DEBOUNCE_FRAMES it SHALL go to REPORT; any other frame result SHALL return to IDLE.
REQ-021 REPORT: tecla_valida=1 and tecla_codigo stable; the block leaves REPORT only on the cycle tecla_ack=1, then goes to WAIT_RELEASE with fcnt=0 and tecla_valida=0 on the next cycle.
REQ-022 Frames that end while in REPORT SHALL be ignored, and no new code SHALL overwrite the held code.
REQ-023 WAIT_RELEASE: a ZERO frame SHALL increment fcnt; a ONE or MULTI frame SHALL clear fcnt; when fcnt reaches DEBOUNCE_FRAMES the FSM SHALL go to IDLE.
REQ-024 A frame end and tecla_ack arriving in the same cycle in REPORT: the ack SHALL take effect, and the frame SHALL not count toward release.
REQ-025 erro_multipla SHALL pulse for one cycle, on the cycle after the frame end, for a MULTI frame in IDLE or DEBOUNCE only.
REQ-026 tecla_valida SHALL rise on the cycle after the frame end that satisfies REQ-019 or REQ-020.
REQ-027 tecla_ack outside REPORT SHALL be ignored.
REQ-028 enable=0 SHALL do all of the following on the next cycle: hold the prescaler and contador at 0, move the FSM to IDLE, clear tecla_valida, and discard the partial frame. Scanning SHALL resume at column 0 once enable returns to 1.

Reset
REQ-029 When rst_n=0 at a clock edge, the following SHALL be cleared, regardless of enable or state:
- colunas=5'b11111, contador=0, prescaler=0
- tecla_valida=0, tecla_codigo=0, erro_multipla=0
- FSM=IDLE, fcnt=0, synchronizer and frame bits =0 (not pressed)
REQ-030 First cycle after release of rst_n with enable=1: colunas=5'b11110.
REQ-031 Reset in any state, including REPORT, SHALL discard a pending code.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=2, frame = 20 cycles)
REQ-032 Scan: after reset, enable=1, no keys -> colunas 11110,11101,11011,10111,01111 repeating, 4 cycles each; contador 0..4; tecla_valida stays 0.
REQ-033 Press: column 2, row 3 held closed (linhas[3]=0 while colunas[2]=0) -> tecla_valida=1 with tecla_codigo=17 one cycle after the end of the 2nd full frame.
REQ-034 Handshake: tecla_ack pulse while key still held -> tecla_valida=0 next cycle, no re-report; release for 2 frames, then press column 4 row 6 -> code 34 reported.
REQ-035 Bounce: code 17 in one frame, ZERO in the next -> FSM back to IDLE, tecla_valida never rises.
REQ-036 Multi: codes 0 and 8 closed together -> erro_multipla 1-cycle pulse after each frame end, tecla_valida stays 0.
REQ-037 Disruption: rst_n=0 for 1 cycle while in REPORT -> all outputs at reset values next cycle; separately, enable=0 mid-frame -> colunas=11111, tecla_valida=0, and after re-enable scanning restarts at column 0.
